// File: rtl/pe_array_seq.sv
// Tile sequencer for a ROWS x COLS systolic PE grid: clear, operand feed,
// skew flush with zero padding, then result-row drain over valid/ready.
module pe_array_seq #(
   parameter  int WIDTH = 8,
   parameter  int ROWS  = 4,
   parameter  int COLS  = 4,
   parameter  int K_W   = 5,
   localparam int RS_W  = $clog2(ROWS) + 1,
   localparam int F_W   = $clog2(ROWS + COLS) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [K_W-1:0]  k_len,
   input  logic            hold,
   output logic            busy,
   output logic            rd_en,
   output logic [K_W-1:0]  rd_addr,
   output logic            pe_clear,
   output logic            pe_enable,
   output logic            zero_pad,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [RS_W-1:0] res_sel,
   output logic            done
);

   if (WIDTH < 1 || ROWS < 1 || COLS < 1 || K_W < 1) begin : g_bad_param
      $error("pe_array_seq: WIDTH, ROWS, COLS and K_W must all be >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_DONE
   } state_t;

   localparam logic [F_W-1:0]  F_LAST = F_W'(ROWS + COLS - 2);
   localparam logic [RS_W-1:0] R_LAST = RS_W'(ROWS - 1);

   state_t          state_q, state_d;
   logic [K_W-1:0]  kreg_q, kreg_d;
   logic [K_W-1:0]  k_q, k_d;
   logic [F_W-1:0]  f_q, f_d;
   logic [RS_W-1:0] r_q, r_d;
   logic            ov_q, ov_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         kreg_q  <= '0;
         k_q     <= '0;
         f_q     <= '0;
         r_q     <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         kreg_q  <= kreg_d;
         k_q     <= k_d;
         f_q     <= f_d;
         r_q     <= r_d;
         ov_q    <= ov_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      kreg_d    = kreg_q;
      k_d       = k_q;
      f_d       = f_q;
      r_d       = r_q;
      ov_d      = ov_q;
      rd_en     = 1'b0;
      pe_enable = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               kreg_d  = k_len;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            k_d     = '0;
            f_d     = '0;
            r_d     = '0;
            ov_d    = 1'b0;
            state_d = (kreg_q == '0) ? S_DRAIN : S_FEED;
         end
         S_FEED: begin
            // The grid consumes the previous read word while the next is fetched.
            rd_en     = ~hold;
            pe_enable = ov_q & ~hold;
            if (rd_en) begin
               k_d  = k_q + K_W'(1);
               ov_d = 1'b1;
               if (k_q == kreg_q - K_W'(1)) state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            pe_enable = ~hold;
            if (!hold) begin
               ov_d = 1'b0;
               if (f_q == F_LAST) state_d = S_DRAIN;
               else               f_d     = f_q + F_W'(1);
            end
         end
         S_DRAIN: begin
            if (out_ready) begin
               if (r_q == R_LAST) state_d = S_DONE;
               else               r_d     = r_q + RS_W'(1);
            end
         end
         S_DONE: begin
            k_d     = '0;
            r_d     = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy      = (state_q != S_IDLE);
   assign rd_addr   = k_q;
   assign pe_clear  = (state_q == S_CLEAR);
   assign zero_pad  = (state_q == S_FLUSH) && (f_q != '0);
   assign out_valid = (state_q == S_DRAIN);
   assign res_sel   = r_q;
   assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_pe_array_seq.sv
// Directed bench for pe_array_seq (ROWS=COLS=4, K_W=5): per-tile event
// timing, hold/ready stalls, k_len boundaries, ignored start and mid-tile reset.
module tb_pe_array_seq;
   localparam int ROWS = 4, COLS = 4, K_W = 5, RS_W = $clog2(ROWS) + 1;

   logic            clk = 1'b0, reset = 1'b1, start = 1'b0, hold = 1'b0, out_ready = 1'b1;
   logic [K_W-1:0]  k_len = '0;
   logic            busy, rd_en, pe_clear, pe_enable, zero_pad, out_valid, done;
   logic [K_W-1:0]  rd_addr;
   logic [RS_W-1:0] res_sel;

   pe_array_seq #(.WIDTH(8), .ROWS(ROWS), .COLS(COLS), .K_W(K_W)) dut (
      .clk(clk), .reset(reset), .start(start), .k_len(k_len), .hold(hold),
      .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .pe_clear(pe_clear),
      .pe_enable(pe_enable), .zero_pad(zero_pad), .out_valid(out_valid),
      .out_ready(out_ready), .res_sel(res_sel), .done(done)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Per-tile observations, cycle j counted from the start-sampling edge.
   int r_clear_j, r_clear_n, r_rd_n, r_rd_first, r_rd_ok;
   int r_pe_n, r_pe_first, r_pe_last, r_zp_n, r_zp_first, r_zp_last;
   int r_hs_n, r_hs_ok, r_val_first, r_stall_bad, r_done_j, r_done_n;

   function automatic int outs_word();
      return int'({busy, rd_en, pe_clear, pe_enable, zero_pad, out_valid, done, rd_addr, res_sel});
   endfunction

   task automatic run_tile(input int k, input logic [63:0] hold_m,
                           input int st_lo, input int st_hi, input int start_j);
      r_clear_j = -1; r_clear_n = 0; r_rd_n = 0; r_rd_first = -1; r_rd_ok = 1;
      r_pe_n = 0; r_pe_first = -1; r_pe_last = -1; r_zp_n = 0; r_zp_first = -1; r_zp_last = -1;
      r_hs_n = 0; r_hs_ok = 1; r_val_first = -1; r_stall_bad = 0; r_done_j = -1; r_done_n = 0;
      k_len = K_W'(k);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int j = 1; j <= 90; j++) begin
         hold      = (j < 64) ? hold_m[j] : 1'b0;
         out_ready = !(j >= st_lo && j <= st_hi);
         start     = (j == start_j);
         @(negedge clk);
         if (pe_clear) begin if (r_clear_n == 0) r_clear_j = j; r_clear_n++; end
         if (rd_en) begin
            if (r_rd_n == 0) r_rd_first = j;
            if (int'(rd_addr) != r_rd_n) r_rd_ok = 0;
            r_rd_n++;
         end
         if (pe_enable) begin if (r_pe_n == 0) r_pe_first = j; r_pe_last = j; r_pe_n++; end
         if (zero_pad) begin if (r_zp_n == 0) r_zp_first = j; r_zp_last = j; r_zp_n++; end
         if (out_valid && r_val_first < 0) r_val_first = j;
         if (out_valid && out_ready) begin
            if (int'(res_sel) != r_hs_n) r_hs_ok = 0;
            r_hs_n++;
         end
         if (!out_ready && (!out_valid || int'(res_sel) != r_hs_n)) r_stall_bad++;
         if (done) begin if (r_done_n == 0) r_done_j = j; r_done_n++; end
         @(posedge clk); #1;
         if (r_done_j >= 0 && j >= r_done_j + 3) break;
      end
      hold = 1'b0; out_ready = 1'b1; start = 1'b0;
   endtask

   task automatic chk_k3(input string p, input int done_j);
      chk({p, "_clear_j"}, r_clear_j, 1);
      chk({p, "_clear_n"}, r_clear_n, 1);
      chk({p, "_rd_n"}, r_rd_n, 3);
      chk({p, "_rd_seq"}, r_rd_ok, 1);
      chk({p, "_pe_n"}, r_pe_n, 9);
      chk({p, "_hs_n"}, r_hs_n, 4);
      chk({p, "_hs_seq"}, r_hs_ok, 1);
      chk({p, "_done_j"}, r_done_j, done_j);
      chk({p, "_done_n"}, r_done_n, 1);
   endtask

   initial begin
      #12;
      chk("reset_outs", outs_word(), 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("idle_busy", int'(busy), 0);

      // T1: plain k=3 tile.
      run_tile(3, '0, 0, -1, -1);
      chk_k3("t1", 16);
      chk("t1_rd_first", r_rd_first, 2);
      chk("t1_pe_first", r_pe_first, 3);
      chk("t1_pe_last", r_pe_last, 11);
      chk("t1_zp_first", r_zp_first, 6);
      chk("t1_zp_last", r_zp_last, 11);
      chk("t1_zp_n", r_zp_n, 6);
      chk("t1_valid_first", r_val_first, 12);

      // T2: hold during FEED at cycles 3 and 4.
      run_tile(3, 64'b11000, 0, -1, -1);
      chk_k3("t2", 18);
      chk("t2_zp_n", r_zp_n, 6);

      // T3: writeback stalls three cycles while row 1 is presented.
      run_tile(3, '0, 13, 15, -1);
      chk_k3("t3", 19);
      chk("t3_stall_bad", r_stall_bad, 0);

      // T4: empty tile goes straight to drain.
      run_tile(0, '0, 0, -1, -1);
      chk("t4_clear_n", r_clear_n, 1);
      chk("t4_rd_n", r_rd_n, 0);
      chk("t4_pe_n", r_pe_n, 0);
      chk("t4_zp_n", r_zp_n, 0);
      chk("t4_hs_n", r_hs_n, 4);
      chk("t4_done_j", r_done_j, 6);

      // T5a: start pulsed in FEED must not disturb the tile.
      run_tile(3, '0, 0, -1, 3);
      chk_k3("t5a", 16);

      // T5b: reset during FLUSH, then a clean tile.
      k_len = K_W'(3);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("t5b_pre_zp", int'(zero_pad), 1);
      #1 reset = 1'b1;
      #1 chk("t5b_rst_outs", outs_word(), 0);
      @(negedge clk);
      reset = 1'b0;
      r_done_n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done || busy) r_done_n++;
      end
      chk("t5b_no_done", r_done_n, 0);
      @(posedge clk); #1;
      run_tile(3, '0, 0, -1, -1);
      chk_k3("t5c", 16);
      chk("t5c_zp_first", r_zp_first, 6);

      // T6: maximum depth.
      run_tile(31, '0, 0, -1, -1);
      chk("t6_rd_n", r_rd_n, 31);
      chk("t6_rd_seq", r_rd_ok, 1);
      chk("t6_pe_n", r_pe_n, 37);
      chk("t6_done_j", r_done_j, 44);
      chk("t6_done_n", r_done_n, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
